// File: rtl/if_id_skid_pkg.sv
// Shared types for the IF/ID skid buffer: occupancy state encoding.
package if_id_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/if_id_skid_pipeline_reg_en.sv
// Enabled pipeline register with an asynchronous, active-high reset value.
module pipeline_reg_en #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/if_id_skid.sv
// IF->ID two-entry skid buffer: main entry drives ID, skid entry absorbs one
// extra fetch so in_ready can be a flop rather than a function of out_ready.
`ifndef INST_NOP
`define INST_NOP 32'h00000013
`endif

module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int                 ADDR_W  = 32,
  parameter int                 INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP_VAL = `INST_NOP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_pred,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_pred
);

  localparam int             PW        = ADDR_W + INSTR_W + 1;
  localparam logic [PW-1:0]  IDLE_WORD = {{ADDR_W{1'b0}}, NOP_VAL, 1'b0};

  skid_state_e   state, state_nxt;
  logic          in_ready_q;
  logic          in_fire, out_fire;
  logic          main_en, skid_en, main_from_skid;
  logic [PW-1:0] in_word, main_d, main_q, skid_q;

  assign in_word   = {in_addr, in_instr, in_pred};
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nxt = ST_ONE;
            main_en   = 1'b1;
          end
        end
        ST_ONE: begin
          case ({in_fire, out_fire})
            2'b10: begin
              state_nxt = ST_FULL;
              skid_en   = 1'b1;
            end
            2'b01:   state_nxt = ST_EMPTY;
            2'b11:   main_en   = 1'b1;
            default: state_nxt = ST_ONE;
          endcase
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can happen
          if (out_fire) begin
            state_nxt      = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state: ready unless skid will be occupied
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_word;

  pipeline_reg_en #(.WIDTH(PW), .RESET_VAL(IDLE_WORD)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  pipeline_reg_en #(.WIDTH(PW), .RESET_VAL('0)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_word),
    .q     (skid_q)
  );

  assign {out_addr, out_instr, out_pred} = out_valid ? main_q : IDLE_WORD;

endmodule

// File: tb/tb_if_id_skid.sv
// Randomized + directed bench for if_id_skid; a FIFO-of-two reference model
// feeds an expected queue that an independent monitor drains on handshakes.
module tb_if_id_skid;

  localparam int          AW  = 32;
  localparam int          IW  = 32;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_ready, in_pred = 1'b0, flush = 1'b0;
  logic          out_valid, out_ready = 1'b0, out_pred;
  logic [AW-1:0] in_addr = '0, out_addr;
  logic [IW-1:0] in_instr = '0, out_instr;

  typedef logic [AW+IW:0] item_t;
  item_t exp_q[$];
  int checks = 0;
  int errors = 0;

  if_id_skid dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_instr(in_instr), .in_pred(in_pred), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_instr(out_instr), .out_pred(out_pred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: check occupancy-derived handshake outputs, then drive.
  task automatic cycle(input logic v, input logic [AW-1:0] a, input logic ordy, input logic fl);
    int   occ;
    logic ir;
    @(negedge clk);
    occ = exp_q.size();
    chk("out_valid", out_valid, occ > 0);
    chk("in_ready", in_ready, occ < 2);
    in_valid  = v;
    in_addr   = a;
    in_instr  = $urandom;
    in_pred   = $urandom_range(0, 1);
    out_ready = ordy;
    flush     = fl;
    if (v && !fl && occ < 2) exp_q.push_back({a, in_instr, in_pred});
    #1 ir = in_ready;
    out_ready = !ordy;
    #1 chk("in_ready_indep", in_ready, ir);
    out_ready = ordy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_instr", out_instr, NOP);
    chk("rst_out_addr", out_addr, '0);
    chk("rst_out_pred", out_pred, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: compare presented payload against the oldest expected entry.
  always begin
    @(negedge clk);
    #3;
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", out_valid, 1'b0);
        end else begin
          chk("payload", {out_addr, out_instr, out_pred}, exp_q[0]);
          if (out_ready && !flush) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_payload", {out_addr, out_instr, out_pred}, {{AW{1'b0}}, NOP, 1'b0});
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_out_instr", out_instr, NOP);
    @(posedge clk);
    #1 reset = 1'b0;

    // streaming, no bubbles
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // backpressure to FULL, extra offer refused, then drain
    cycle(1'b1, 32'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h104, 1'b0, 1'b0);
    cycle(1'b1, 32'h108, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // flush while FULL with a simultaneous offer
    cycle(1'b1, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 1'b0, 1'b0);
    cycle(1'b1, 32'h200, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // simultaneous in/out while ONE
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

    // reset from a full buffer, then accept on the first edge after release
    cycle(1'b1, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 32'h404, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 32'h500, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) do_reset();
      cycle($urandom_range(0, 9) < 6, {$urandom_range(0, 32'h3fff_ffff), 2'b00},
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch address width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter NOP_VAL, default `INST_NOP, instruction word presented whenever out_valid is 0.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  IF presents a fetched instruction.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port in_addr  input  ADDR_W  fetch PC.
REQ-009 SHALL have port in_instr  input  INSTR_W  fetched instruction.
REQ-010 SHALL have port in_pred  input  1  branch-predicted-taken flag from IF.
REQ-011 SHALL have port flush  input  1  squash all held instructions (branch mispredict/trap).
REQ-012 SHALL have port out_valid  output  1  ID-side instruction valid.
REQ-013 SHALL have port out_ready  input  1  ID accepts this cycle.
REQ-014 SHALL have ports out_addr (ADDR_W), out_instr (INSTR_W), out_pred (1), all outputs, ID-side payload.

Function
REQ-015 SHALL hold up to two entries: main (drives outputs) and skid; payload = {addr, instr, pred}.
REQ-016 SHALL drive in_ready = NOT skid_valid, directly from a flop (no combinational path from out_ready).
REQ-017 SHALL transfer on input when in_valid AND in_ready; on output when out_valid AND out_ready.
REQ-018 SHALL use states EMPTY (0 entries), ONE (main only), FULL (main+skid); out_valid = (state != EMPTY).
REQ-019 EMPTY: input transfer -> ONE, data into main.
REQ-020 ONE: input only -> FULL (data into skid); output only -> EMPTY; both -> ONE, new data into main; neither -> hold.
REQ-021 FULL: output transfer -> ONE, skid moves to main; no input accepted (in_ready=0).
REQ-022 SHALL hold main payload stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive out_instr = NOP_VAL, out_addr = 0, out_pred = 0 whenever out_valid = 0.
REQ-024 flush SHALL take priority: next state EMPTY, in-cycle input discarded, in_ready=1 next cycle.
REQ-025 Latency SHALL be one cycle: data accepted at edge N is on outputs after edge N, given EMPTY or ONE-with-drain.
REQ-026 Throughput SHALL be one instruction per cycle when out_ready held 1.
REQ-027 No payload arithmetic; widths pass through unmodified.

Reset
REQ-028 On reset assertion, SHALL asynchronously enter EMPTY: out_valid=0, in_ready=1, out_instr=NOP_VAL, out_addr=0, out_pred=0, skid cleared.
REQ-029 Reset mid-operation SHALL discard both entries; no transfer reported in that cycle.
REQ-030 First input transfer SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-031 NOP_VAL default SHALL come from `INST_NOP in define.v; no new shared constants.
REQ-032 SHALL instantiate one sub-module, pipeline_reg_en (parametrised width, enable, async reset value), once for main and once for skid.
REQ-033 State/control logic SHALL reside in if_id_skid itself.

Verification
REQ-034 Reset: assert reset mid-cycle -> immediately out_valid=0, out_instr=0x00000013, in_ready=1.
REQ-035 Streaming: in_valid=1 for 4 cycles, addr 0x0,0x4,0x8,0xC, out_ready=1 -> same sequence on out_addr one cycle later, no bubbles.
REQ-036 Backpressure: out_ready=0 with addr 0x100,0x104 sent -> FULL, in_ready=0, out_addr holds 0x100; release -> 0x100 then 0x104, no loss/duplication.
REQ-037 Flush in FULL with in_valid=1 (addr 0x200) -> next cycle out_valid=0, out_instr=NOP, 0x200 never appears.
REQ-038 Simultaneous in/out in ONE: main 0x10, input 0x14, out_ready=1 -> next cycle main=0x14, state ONE.
REQ-039 Random in_valid/out_ready/flush, 10k cycles -> scoreboard order matches, in_ready never depends combinationally on out_ready.
